// File: rtl/ws2812_pixel_driver.sv
// WS2812 serializer: fetches one 24-bit RGB colour per pixel via pixel_req/led_idx,
// sends it GRB MSB-first with T0H/T1H/TBIT timing, then holds the line low for the latch gap.
module ws2812_pixel_driver #(
    parameter int unsigned T0H    = 20,
    parameter int unsigned T1H    = 40,
    parameter int unsigned TBIT   = 63,
    parameter int unsigned TLATCH = 15000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [9:0]  num_leds_i,
    input  logic [23:0] cor_in_i,
    output logic        pixel_req_o,
    output logic [9:0]  led_idx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        dout_o
);

    localparam int unsigned CMAX = (TBIT > TLATCH) ? TBIT : TLATCH;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    // Down-counter reload values; each phase ends when the counter reaches zero.
    localparam logic [CW-1:0] C_H0    = CW'(T0H - 1);
    localparam logic [CW-1:0] C_H1    = CW'(T1H - 1);
    localparam logic [CW-1:0] C_L0    = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] C_L1    = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] C_LATCH = CW'(TLATCH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_LOAD, S_HIGH, S_LOW, S_LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic [9:0]    num_q, num_d;
    logic [9:0]    idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        num_d   = num_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_d  = num_leds_i;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (num_leds_i == 10'd0) begin
                        state_d = S_LATCH;
                        cnt_d   = C_LATCH;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = {cor_in_i[15:8], cor_in_i[23:16], cor_in_i[7:0]};
                bit_d   = '0;
                cnt_d   = cor_in_i[15] ? C_H1 : C_H0;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = shift_q[23] ? C_L1 : C_L0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_q != 5'd23) begin
                        bit_d   = bit_q + 5'd1;
                        cnt_d   = shift_q[22] ? C_H1 : C_H0;
                        state_d = S_HIGH;
                    end else if (idx_q < num_q - 10'd1) begin
                        idx_d   = idx_q + 10'd1;
                        state_d = S_REQ;
                    end else begin
                        cnt_d   = C_LATCH;
                        state_d = S_LATCH;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pixel_req_o = (state_q == S_REQ);
    assign dout_o      = (state_q == S_HIGH);
    assign led_idx_o   = idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ws2812_pixel_driver.sv
// Bench for ws2812_pixel_driver: a dout decoder checks pulse widths and compares each
// decoded GRB word with the colour queued when pixel_req was seen.
module tb_ws2812_pixel_driver;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TLATCH = 300;
    localparam int FRAME_BUDGET = 3 * (24 * TBIT + 3) + TLATCH + 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  num_leds;
    logic [23:0] cor_in;
    logic        pixel_req;
    logic [9:0]  led_idx;
    logic        busy;
    logic        done;
    logic        dout;

    ws2812_pixel_driver #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .num_leds_i(num_leds),
        .cor_in_i(cor_in), .pixel_req_o(pixel_req), .led_idx_o(led_idx),
        .busy_o(busy), .done_o(done), .dout_o(dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] tab [4];
    assign cor_in = tab[led_idx[1:0]];

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_q [$];
    int          req_log [$];
    int          done_cnt = 0;
    int          high_samples = 0;
    int          words = 0;
    logic        prev = 1'b0;
    int          hcnt = 0;
    int          nbits = 0;
    logic [23:0] acc = '0;
    logic [23:0] last_word = '0;
    int          last_fall = 0;

    // Decoder and scoreboard, sampled on the falling clock edge.
    always @(negedge clk) begin
        logic [23:0] c;
        logic [23:0] e;
        if (rst) begin
            prev = 1'b0; hcnt = 0; nbits = 0; acc = '0;
            exp_q.delete();
        end else begin
            if (pixel_req) begin
                c = tab[led_idx[1:0]];
                exp_q.push_back({c[15:8], c[23:16], c[7:0]});
                req_log.push_back(int'(led_idx));
            end
            if (done) done_cnt++;
            if (dout) begin
                hcnt++;
                high_samples++;
            end else if (prev) begin
                n_cmp++;
                if (hcnt != T0H && hcnt != T1H) begin
                    n_err++;
                    $display("FAIL bit_width: got %0d high cycles, want %0d or %0d", hcnt, T0H, T1H);
                end
                acc = {acc[22:0], (hcnt == T1H)};
                nbits++;
                last_fall = cyc;
                hcnt = 0;
                if (nbits == 24) begin
                    nbits = 0;
                    last_word = acc;
                    words++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL pixel_word: got %06h with nothing expected", acc);
                    end else begin
                        e = exp_q.pop_front();
                        if (acc !== e) begin
                            n_err++;
                            $display("FAIL pixel_word: got %06h want %06h", acc, e);
                        end
                    end
                end
            end
            prev = dout;
        end
    end

    task automatic pulse_start(input int n);
        num_leds = 10'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_leds = 10'h3FF;
    endtask

    // Leaves the caller on the negedge where done is high (or after the budget expires).
    task automatic wait_done(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < budget) begin
            if (done === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (dout !== 1'b0)       begin n_err++; $display("FAIL reset_dout: got %b want 0", dout); end
        if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        if (pixel_req !== 1'b0)  begin n_err++; $display("FAIL reset_req: got %b want 0", pixel_req); end
        if (led_idx !== 10'd0)   begin n_err++; $display("FAIL reset_idx: got %0d want 0", led_idx); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        tab[0] = 24'hFF0000;
        req_log.delete();
        pulse_start(1);
        n_cmp += 3;
        if (busy !== 1'b1)      begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        if (pixel_req !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", pixel_req); end
        if (led_idx !== 10'd0)  begin n_err++; $display("FAIL single_idx: got %0d want 0", led_idx); end
        wait_done(FRAME_BUDGET, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_done_timeout: got no done want done"); end
        n_cmp += 5;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
        if (cyc - last_fall != (TBIT - T0H) + TLATCH)
            begin n_err++; $display("FAIL single_latch_gap: got %0d want %0d", cyc - last_fall, (TBIT - T0H) + TLATCH); end
        if (last_word !== 24'h00FF00) begin n_err++; $display("FAIL single_word: got %06h want 00ff00", last_word); end
        if (req_log.size() != 1) begin n_err++; $display("FAIL single_req_count: got %0d want 1", req_log.size()); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL single_leftover: got %0d want 0", exp_q.size()); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL single_done_width: got %b want 0", done); end
    endtask

    task automatic test_multi;
        bit ok;
        int w0;
        tab[0] = 24'h00FF00; tab[1] = 24'h0000FF; tab[2] = 24'h123456;
        req_log.delete();
        w0 = words;
        pulse_start(3);
        wait_done(FRAME_BUDGET, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL multi_done_timeout: got no done want done"); end
        if (words - w0 != 3) begin n_err++; $display("FAIL multi_words: got %0d want 3", words - w0); end
        if (req_log.size() != 3) begin n_err++; $display("FAIL multi_req_count: got %0d want 3", req_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (req_log[i] != i) begin n_err++; $display("FAIL multi_req_idx: got %0d want %0d", req_log[i], i); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        bit ok;
        int t0;
        int hs;
        hs = high_samples;
        num_leds = 10'd0;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", busy); end
        wait_done(TLATCH + 50, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL zero_done_timeout: got no done want done"); end
        if (cyc - t0 != TLATCH + 1) begin n_err++; $display("FAIL zero_done_time: got %0d want %0d", cyc - t0, TLATCH + 1); end
        if (high_samples != hs) begin n_err++; $display("FAIL zero_no_pulses: got %0d high cycles want 0", high_samples - hs); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit ok;
        tab[0] = 24'hA5A5A5; tab[1] = 24'h5A0F3C;
        req_log.delete();
        pulse_start(2);
        repeat (500) @(negedge clk);
        pulse_start(7);
        wait_done(FRAME_BUDGET, ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL ignore_done_timeout: got no done want done"); end
        if (req_log.size() != 2) begin n_err++; $display("FAIL ignore_req_count: got %0d want 2", req_log.size()); end
        tab[0] = 24'hC33C81;
        req_log.delete();
        pulse_start(1);
        n_cmp += 2;
        if (pixel_req !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %b want 1", pixel_req); end
        if (busy !== 1'b1)      begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(FRAME_BUDGET, ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL b2b_done_timeout: got no done want done"); end
        if (last_word !== 24'h3CC381) begin n_err++; $display("FAIL b2b_word: got %06h want 3cc381", last_word); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int i;
        int dc;
        int w0;
        tab[0] = 24'hFFFFFF; tab[1] = 24'h00FF00;
        pulse_start(2);
        i = 0;
        while (dout !== 1'b1 && i < 100) begin @(negedge clk); i++; end
        n_cmp++;
        if (dout !== 1'b1) begin n_err++; $display("FAIL midrst_high_timeout: got %b want 1", dout); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (dout !== 1'b0) begin n_err++; $display("FAIL midrst_dout: got %b want 0", dout); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        dc = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (TLATCH + 100) @(negedge clk);
        n_cmp++;
        if (done_cnt != dc) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - dc); end
        tab[0] = 24'h0F1E2D;
        w0 = words;
        pulse_start(1);
        wait_done(FRAME_BUDGET, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL midrst_clean_timeout: got no done want done"); end
        if (words - w0 != 1) begin n_err++; $display("FAIL midrst_clean_words: got %0d want 1", words - w0); end
        if (last_word !== 24'h1E0F2D) begin n_err++; $display("FAIL midrst_clean_word: got %06h want 1e0f2d", last_word); end
        @(negedge clk);
    endtask

    // Stand-in fader: red steps down each frame towards zero.
    task automatic test_fade;
        bit ok;
        logic [7:0] red;
        int prev_r;
        int r;
        int f;
        red = 8'hFF;
        prev_r = 256;
        r = 256;
        f = 0;
        while (r != 0 && f < 8) begin
            tab[0] = {red, 8'h10, 8'h20};
            pulse_start(1);
            wait_done(FRAME_BUDGET, ok);
            r = int'(last_word[15:8]);
            n_cmp += 3;
            if (!ok) begin n_err++; $display("FAIL fade_timeout: got no done want done"); end
            if (r > prev_r) begin n_err++; $display("FAIL fade_monotonic: got %0d want <= %0d", r, prev_r); end
            if (r != int'(red)) begin n_err++; $display("FAIL fade_red: got %0d want %0d", r, red); end
            prev_r = r;
            red = (red >= 8'h40) ? red - 8'h40 : 8'h00;
            f++;
            @(negedge clk);
        end
        n_cmp++;
        if (r != 0) begin n_err++; $display("FAIL fade_final: got %0d want 0", r); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_leds = 10'd0;
        for (int i = 0; i < 4; i++) tab[i] = 24'h000000;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 200000 cycles");
        $fatal(1);
    end

endmodule
